// File: rtl/mash_dac_pkg.sv
// mash_dac_pkg: shared MASH DAC width default, frame length and signed-to-offset code mapping
package mash_dac_pkg;
  localparam int DEF_DAC_BW = 4;
  function automatic int frame_len(input int bw);
    return (1 << bw) - 1;
  endfunction
  function automatic logic [15:0] signed_to_offset(input logic [15:0] c, input int bw);
    return c ^ (16'd1 << (bw - 1));
  endfunction
endpackage

// File: rtl/mash_pwm_out_counter.sv
// pwm_frame_counter: free-running PWM slot counter with frame_end and registered frame_start
module pwm_frame_counter #(
  parameter int W   = 4,
  parameter int LEN = 15
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  output logic [W-1:0] o_slot_nxt,
  output logic         o_frame_end,
  output logic         o_frame_start
);
  logic [W-1:0] r_slot;
  logic         r_frame_start;
  assign o_frame_end   = r_slot == W'(LEN - 1);
  assign o_slot_nxt    = o_frame_end ? '0 : r_slot + 1'b1;
  assign o_frame_start = r_frame_start;
  // Resetting to the last slot makes the first edge after release open frame 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_slot        <= W'(LEN - 1);
      r_frame_start <= 1'b0;
    end else begin
      r_slot        <= o_slot_nxt;
      r_frame_start <= o_frame_end;
    end
  end
endmodule

// File: rtl/mash_pwm_out.sv
// mash_pwm_out: one-deep buffered AXI-Stream MASH code to edge-aligned PWM frame output stage
module mash_pwm_out
  import mash_dac_pkg::*;
#(
  parameter int DAC_BW = DEF_DAC_BW
) (
  input  logic              aclk,
  input  logic              arst_n,
  input  logic [DAC_BW-1:0] s_axis_data_tdata,
  input  logic              s_axis_data_tvalid,
  output logic              s_axis_data_tready,
  output logic              pwm_out,
  output logic              frame_start,
  output logic              underrun
);
  localparam int                FL  = frame_len(DAC_BW);
  localparam logic [DAC_BW-1:0] MID = DAC_BW'(1 << (DAC_BW - 1));
  logic [DAC_BW-1:0] w_slot_nxt, w_code, w_active_nxt;
  logic              w_frame_end, w_xfer, w_load;
  logic [DAC_BW-1:0] r_buf_code, r_active;
  logic              r_buf_valid, r_pwm, r_underrun, r_first;
  pwm_frame_counter #(.W(DAC_BW), .LEN(FL)) u_cnt (
    .i_clk        (aclk),
    .i_rst_n      (arst_n),
    .o_slot_nxt   (w_slot_nxt),
    .o_frame_end  (w_frame_end),
    .o_frame_start(frame_start)
  );
  assign w_code             = DAC_BW'(signed_to_offset(16'(s_axis_data_tdata), DAC_BW));
  assign s_axis_data_tready = !r_buf_valid || w_frame_end;
  assign w_xfer             = s_axis_data_tvalid && s_axis_data_tready;
  assign w_load             = w_frame_end && r_buf_valid;
  assign w_active_nxt       = w_load ? r_buf_code : r_active;
  assign pwm_out            = r_pwm;
  assign underrun           = r_underrun;
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      r_buf_code  <= '0;
      r_buf_valid <= 1'b0;
      r_active    <= MID;
      r_pwm       <= 1'b0;
      r_underrun  <= 1'b0;
      r_first     <= 1'b1;
    end else begin
      if (w_xfer) begin
        r_buf_code  <= w_code;
        r_buf_valid <= 1'b1;
      end else if (w_load) begin
        r_buf_valid <= 1'b0;
      end
      r_active   <= w_active_nxt;
      r_pwm      <= w_slot_nxt < w_active_nxt;
      r_underrun <= w_frame_end && !r_buf_valid && !r_first;
      r_first    <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mash_pwm_out.sv
// tb_mash_pwm_out: table-driven, directed and randomized checks against a frame-level reference model
module tb_mash_pwm_out;
  logic       aclk = 1'b0;
  logic       arst_n = 1'b1;
  logic [3:0] tdata = '0;
  logic       tvalid = 1'b0;
  logic       tready, pwm_out, frame_start, underrun;
  int         checks = 0;
  int         errors = 0;
  int         m_p, m_active;
  int         q[$];
  bit         m_first, m_miss, rnd;
  logic [3:0] src[$];
  typedef struct {logic [3:0] tdata; int highs;} vec_t;
  vec_t vt[6];

  mash_pwm_out #(.DAC_BW(4)) dut (
    .aclk              (aclk),
    .arst_n            (arst_n),
    .s_axis_data_tdata (tdata),
    .s_axis_data_tvalid(tvalid),
    .s_axis_data_tready(tready),
    .pwm_out           (pwm_out),
    .frame_start       (frame_start),
    .underrun          (underrun)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  task automatic drive();
    if (rnd) begin
      tvalid = $urandom_range(0, 2) == 0;
      tdata  = 4'($urandom);
    end else begin
      tvalid = src.size() > 0;
      tdata  = src.size() > 0 ? src[0] : 4'd0;
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_p = 14;
    m_active = 8;
    m_first = 1;
    m_miss = 0;
  endtask

  // One clock: check tready before the edge, advance the frame model, check outputs just after.
  task automatic step();
    bit exp_rdy, xfer;
    exp_rdy = (q.size() == 0) || (m_p == 14);
    chk("tready", int'(tready), int'(exp_rdy));
    @(posedge aclk);
    xfer = tvalid && exp_rdy;
    if (m_p == 14) begin
      if (q.size() > 0) begin
        m_active = q.pop_front();
        m_miss = 0;
      end else m_miss = !m_first;
    end
    if (xfer) begin
      q.push_back(int'($signed(tdata)) + 8);
      if (!rnd) void'(src.pop_front());
    end
    m_first = 0;
    m_p = (m_p + 1) % 15;
    #1;
    chk("pwm_out", int'(pwm_out), int'(m_p < m_active));
    chk("frame_start", int'(frame_start), int'(m_p == 0));
    chk("underrun", int'(underrun), int'(m_p == 0 && m_miss));
    drive();
  endtask

  task automatic frame_highs(output int n, output int ur0);
    int k = 0;
    while (!frame_start && k < 20) begin
      step();
      k++;
    end
    chk("frame_start_wait", int'(frame_start), 1);
    n = int'(pwm_out);
    ur0 = int'(underrun);
    repeat (14) begin
      step();
      n += int'(pwm_out);
    end
  endtask

  task automatic do_reset();
    #2 arst_n = 1'b0;
    #1;
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_fs", int'(frame_start), 0);
    chk("rst_ur", int'(underrun), 0);
    chk("rst_tready", int'(tready), 1);
    model_reset();
    src.delete();
    rnd = 0;
    drive();
    repeat (2) @(posedge aclk);
    #3 arst_n = 1'b1;
  endtask

  initial begin
    int n, u;
    vt[0] = '{4'h8, 0};
    vt[1] = '{4'h7, 15};
    vt[2] = '{4'h0, 8};
    vt[3] = '{4'h3, 11};
    vt[4] = '{4'hE, 6};
    vt[5] = '{4'h1, 9};
    model_reset();
    do_reset();
    for (int f = 0; f < 4; f++) begin
      frame_highs(n, u);
      chk("idle_highs", n, 8);
      chk("idle_underrun", u, f > 0 ? 1 : 0);
    end
    for (int i = 0; i < 6; i++) begin
      do_reset();
      repeat (6) src.push_back(vt[i].tdata);
      drive();
      frame_highs(n, u);
      chk("const_first_mid", n, 8);
      for (int f = 0; f < 2; f++) begin
        frame_highs(n, u);
        chk("const_highs", n, vt[i].highs);
        chk("const_underrun", u, 0);
      end
    end
    do_reset();
    src = '{4'd3, 4'hE, 4'd7};
    drive();
    frame_highs(n, u);
    chk("stream_mid", n, 8);
    for (int f = 0; f < 3; f++) begin
      frame_highs(n, u);
      chk("stream_highs", n, f == 0 ? 11 : f == 1 ? 6 : 15);
      chk("stream_underrun", u, 0);
    end
    do_reset();
    frame_highs(n, u);
    repeat (6) step();
    chk("single_slot", m_p, 5);
    src = '{4'd1};
    drive();
    frame_highs(n, u);
    chk("single_highs", n, 9);
    chk("single_no_ur", u, 0);
    for (int f = 0; f < 2; f++) begin
      frame_highs(n, u);
      chk("repeat_highs", n, 9);
      chk("repeat_ur", u, 1);
    end
    do_reset();
    src = '{4'd7, 4'd7, 4'hE};
    drive();
    frame_highs(n, u);
    frame_highs(n, u);
    chk("pre_rst_highs", n, 15);
    repeat (8) step();
    chk("pre_rst_pwm", int'(pwm_out), 1);
    do_reset();
    frame_highs(n, u);
    chk("post_rst_highs", n, 8);
    chk("post_rst_ur", u, 0);
    frame_highs(n, u);
    chk("post_rst_lost", n, 8);
    chk("post_rst_ur2", u, 1);
    do_reset();
    rnd = 1;
    drive();
    repeat (900) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
